uart_text_rx: RTL and testbench

//   Serial receiver that turns an asynchronous 8N1 UART line into the byte

---
 rtl/uart_text_rx.sv | 145 ++++++++++++++
 tb/tb_uart_text_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_text_rx.sv
// 8N1 UART receiver feeding the keyword interrupt block: one text_in strobe per
// good frame, frame_err on a low stop bit, then hold in BREAK until the line recovers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing to mid start bit, rejects glitches shorter than that
// S_DATA  | sampling 8 data bits LSB first at bit centres
// S_STOP  | sampling the stop bit, emits text_in or frame_err
// S_BREAK | stop bit was low, waiting for the line to return high
module uart_text_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx,
    output logic [7:0] text,
    output logic       text_in,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      text_q, text_d;
    logic            text_in_q, text_in_d;
    logic            frame_err_q, frame_err_d;
    logic            busy_q, busy_d;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        text_d      = text_q;
        text_in_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_TC) begin
                    shreg_d[idx_q] = rx_s;
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        text_d    = shreg_q;
                        text_in_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                // A held-low line must not be mistaken for a new start bit.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'h00;
            text_q      <= 8'h00;
            text_in_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            text_q      <= text_d;
            text_in_q   <= text_in_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign text      = text_q;
    assign text_in   = text_in_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_text_rx.sv
// Directed bench for uart_text_rx at 16 clocks per bit: good frames, back-to-back
// frames, glitch rejection, framing error with break, mid-frame reset and idle line.
module tb_uart_text_rx;

    localparam int CPB = 16;
    // Line fall -> 2 sync flops -> START entered (t0) = 3 edges; text_in seen after t0+152.
    localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] text;
    logic       text_in;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int n_txt    = 0;
    int n_err    = 0;
    int adj_viol = 0;
    int strobe_cyc [0:31];
    logic [7:0] strobe_val [0:31];
    int err_cyc  = 0;
    logic prev_txt = 1'b0;
    logic prev_err = 1'b0;

    uart_text_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx        (rx),
        .text      (text),
        .text_in   (text_in),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Strobe monitor samples 2 ns after each rising edge.
    always @(posedge CLK) begin
        cyc++;
        #2;
        if (text_in) begin
            if (n_txt < 32) begin
                strobe_cyc[n_txt] = cyc;
                strobe_val[n_txt] = text;
            end
            n_txt++;
        end
        if (frame_err) begin
            err_cyc = cyc;
            n_err++;
        end
        if ((text_in && frame_err) || (text_in && prev_err) || (frame_err && prev_txt))
            adj_viol++;
        prev_txt = text_in;
        prev_err = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge CLK);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_txt;
        int base_err;
        int idle_viol;
        int k_fall;

        repeat (3) @(negedge CLK);
        check("rst_text", {24'h0, text}, 32'h00);
        check("rst_text_in", {31'h0, text_in}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        RST = 1'b0;

        // Idle line for 1000 cycles
        idle_viol = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (busy || text_in || frame_err) idle_viol++;
        end
        check("idle_quiet", idle_viol, 0);

        // Single 'K'
        base_txt = n_txt;
        base_err = n_err;
        send_byte(8'h4B, 1'b1);
        k_fall = fall_cyc;
        repeat (4) @(negedge CLK);
        check("k_count", n_txt - base_txt, 1);
        check("k_text", {24'h0, strobe_val[base_txt]}, 32'h4B);
        check("k_latency", strobe_cyc[base_txt] - k_fall, LATENCY);
        check("k_no_err", n_err - base_err, 0);
        check("k_idle", {31'h0, busy}, 32'h0);

        // 'K','E','Y' back to back
        base_txt = n_txt;
        send_byte(8'h4B, 1'b1);
        send_byte(8'h45, 1'b1);
        send_byte(8'h59, 1'b1);
        repeat (4) @(negedge CLK);
        check("key_count", n_txt - base_txt, 3);
        check("key_k", {24'h0, strobe_val[base_txt]}, 32'h4B);
        check("key_e", {24'h0, strobe_val[base_txt + 1]}, 32'h45);
        check("key_y", {24'h0, strobe_val[base_txt + 2]}, 32'h59);
        check("key_gap1", strobe_cyc[base_txt + 1] - strobe_cyc[base_txt], 10 * CPB);
        check("key_gap2", strobe_cyc[base_txt + 2] - strobe_cyc[base_txt + 1], 10 * CPB);
        repeat (20) @(negedge CLK);

        // 4-cycle glitch
        base_txt = n_txt;
        base_err = n_err;
        rx = 1'b0;
        repeat (4) @(negedge CLK);
        rx = 1'b1;
        repeat (8) @(negedge CLK);
        check("glitch_busy", {31'h0, busy}, 32'h0);
        repeat (40) @(negedge CLK);
        check("glitch_no_txt", n_txt - base_txt, 0);
        check("glitch_no_err", n_err - base_err, 0);

        // 0xA5 with low stop bit, then held low
        base_txt = n_txt;
        base_err = n_err;
        send_byte(8'hA5, 1'b0);
        k_fall = fall_cyc;
        repeat (64) @(negedge CLK);
        check("brk_err_count", n_err - base_err, 1);
        check("brk_err_time", err_cyc - k_fall, LATENCY);
        check("brk_no_txt", n_txt - base_txt, 0);
        check("brk_text_kept", {24'h0, text}, 32'h59);
        check("brk_busy", {31'h0, busy}, 32'h1);
        rx = 1'b1;
        repeat (5) @(negedge CLK);
        check("brk_exit", {31'h0, busy}, 32'h0);
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge CLK);
        check("after_brk_count", n_txt - base_txt, 1);
        check("after_brk_text", {24'h0, text}, 32'h3C);
        check("after_brk_err", n_err - base_err, 1);

        // Reset during data bit 4 of 0x55
        base_txt = n_txt;
        base_err = n_err;
        rx = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            repeat (CPB) @(negedge CLK);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge CLK);
        check("rst_mid_busy_before", {31'h0, busy}, 32'h1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_mid_busy", {31'h0, busy}, 32'h0);
        check("rst_mid_text", {24'h0, text}, 32'h00);
        repeat (40) @(negedge CLK);
        check("rst_mid_no_txt", n_txt - base_txt, 0);
        check("rst_mid_no_err", n_err - base_err, 0);
        send_byte(8'h59, 1'b1);
        repeat (4) @(negedge CLK);
        check("rst_next_count", n_txt - base_txt, 1);
        check("rst_next_text", {24'h0, text}, 32'h59);

        check("strobe_exclusive", adj_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
